// File: rtl/vga_fb_writer_if.sv
// Command and framebuffer-write bundle for vga_fb_writer.
// The master side offers fill commands and the blank indication, and it observes
// the framebuffer write port and the busy flag.
interface vga_fb_writer_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 8,
   parameter int LEN_W  = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_data;
   logic [LEN_W-1:0]  cmd_len;
   logic              blank;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic              sel_rw;
   logic              busy;

   modport master (
      output cmd_valid, cmd_addr, cmd_data, cmd_len, blank,
      input  cmd_ready, waddr, wdata, sel_rw, busy
   );

   modport slave (
      input  cmd_valid, cmd_addr, cmd_data, cmd_len, blank,
      output cmd_ready, waddr, wdata, sel_rw, busy
   );
endinterface

// File: rtl/vga_fb_writer.sv
// vga_fb_writer: queues fill commands (address, pixel value, length) and expands
// each command into a run of single-pixel framebuffer writes at consecutive
// addresses.
// Optional feature: define VGA_FB_BLANK_ONLY_EN so that writes are issued only
// while the blank input is high. When the macro is undefined, blank is ignored.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no fill in progress; pops the FIFO head when one is queued
// S_ACTIVE | expanding the current command, one write per enabled cycle
module vga_fb_writer #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 8,
   parameter int LEN_W      = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   vga_fb_writer_if.slave bus
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("vga_fb_writer: FIFO_DEPTH must be a power of 2 and at least 2");
   end

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACTIVE = 1'b1
   } state_t;

   logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
   logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
   logic [LEN_W-1:0]  r_fifo_len  [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;

   state_t            r_state;
   logic [ADDR_W-1:0] r_cur_addr;
   logic [DATA_W-1:0] r_cur_data;
   logic [LEN_W-1:0]  r_remaining;
   logic [ADDR_W-1:0] r_waddr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_sel_rw;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;
   logic w_issue_en;

`ifdef VGA_FB_BLANK_ONLY_EN
   assign w_issue_en = bus.blank;
`else
   assign w_issue_en = 1'b1;
`endif

   assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_empty = (r_count == '0);
   // A full FIFO drops the offer, so queued entries are never overwritten.
   assign w_push  = bus.cmd_valid & ~w_full;
   // The head is taken only when the engine is free, so it moves to S_ACTIVE on the same edge.
   assign w_pop   = (r_state == S_IDLE) & ~w_empty;

   // Command storage. It has no reset because occupancy is tracked by the pointers and the count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_addr[r_wr_ptr] <= bus.cmd_addr;
         r_fifo_data[r_wr_ptr] <= bus.cmd_data;
         r_fifo_len[r_wr_ptr]  <= bus.cmd_len;
      end
   end

   // FIFO pointers and occupancy. A push and a pop on the same edge leave the count unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Fill engine with registered write port. Stalled cycles hold the address and the count, so no pixel is skipped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cur_addr  <= '0;
         r_cur_data  <= '0;
         r_remaining <= '0;
         r_waddr     <= '0;
         r_wdata     <= '0;
         r_sel_rw    <= 1'b0;
      end else begin
         r_sel_rw <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (!w_empty) begin
                  r_cur_addr  <= r_fifo_addr[r_rd_ptr];
                  r_cur_data  <= r_fifo_data[r_rd_ptr];
                  r_remaining <= r_fifo_len[r_rd_ptr];
                  r_state     <= S_ACTIVE;
               end
            end
            S_ACTIVE: begin
               if (w_issue_en) begin
                  r_sel_rw   <= 1'b1;
                  r_waddr    <= r_cur_addr;
                  r_wdata    <= r_cur_data;
                  r_cur_addr <= r_cur_addr + ADDR_W'(1);
                  if (r_remaining == '0) r_state <= S_IDLE;
                  else                   r_remaining <= r_remaining - LEN_W'(1);
               end
            end
         endcase
      end
   end

   assign bus.cmd_ready = ~w_full;
   assign bus.busy      = ~w_empty | (r_state == S_ACTIVE);
   assign bus.waddr     = r_waddr;
   assign bus.wdata     = r_wdata;
   assign bus.sel_rw    = r_sel_rw;

endmodule

// File: tb/tb_vga_fb_writer.sv
// Testbench for vga_fb_writer. It tracks VGA_FB_BLANK_ONLY_EN so that the same
// bench covers both builds.
module tb_vga_fb_writer;

`ifdef VGA_FB_BLANK_ONLY_EN
   localparam bit BLANK_ONLY = 1'b1;
`else
   localparam bit BLANK_ONLY = 1'b0;
`endif

   logic clk;
   logic rst;

   vga_fb_writer_if #(.ADDR_W(32), .DATA_W(8), .LEN_W(8)) bus ();
   vga_fb_writer_if #(.ADDR_W(8),  .DATA_W(8), .LEN_W(8)) bus8 ();

   vga_fb_writer #(.ADDR_W(32), .DATA_W(8), .LEN_W(8), .FIFO_DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   vga_fb_writer #(.ADDR_W(8), .DATA_W(8), .LEN_W(8), .FIFO_DEPTH(4)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [31:0] obs_addr [$];
   logic [7:0]  obs_data [$];
   int          obs_cyc  [$];
   logic [31:0] exp_addr [$];
   logic [7:0]  exp_data [$];

   // Advance one clock and log any write that was registered on that edge.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (bus.sel_rw === 1'b1) begin
         obs_addr.push_back(bus.waddr);
         obs_data.push_back(bus.wdata);
         obs_cyc.push_back(cyc);
      end
   endtask

   task automatic clear_obs();
      obs_addr.delete();
      obs_data.delete();
      obs_cyc.delete();
      exp_addr.delete();
      exp_data.delete();
   endtask

   // Reference model: a fill command writes len+1 pixels at consecutive addresses, wrapping modulo 2^32.
   task automatic model_cmd(input logic [31:0] a, input logic [7:0] d, input logic [7:0] len);
      for (int i = 0; i <= int'(len); i++) begin
         exp_addr.push_back(a + 32'(i));
         exp_data.push_back(d);
      end
   endtask

   task automatic send_cmd(input logic [31:0] a, input logic [7:0] d, input logic [7:0] len,
                           output bit ok);
      bus.cmd_addr  = a;
      bus.cmd_data  = d;
      bus.cmd_len   = len;
      bus.cmd_valid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 400 && !ok; k++) begin
         if (bus.cmd_ready === 1'b1) ok = 1'b1;
         step();
      end
      bus.cmd_valid = 1'b0;
   endtask

   task automatic drain(input int bound);
      for (int k = 0; k < bound && bus.busy !== 1'b0; k++) step();
      step();
      step();
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL drain_timeout: busy=%0b required 0", bus.busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks += 6;
      if (bus.sel_rw !== 1'b0)      begin failures++; $display("FAIL rst_sel_rw: got %0b want 0", bus.sel_rw); end
      if (bus.waddr !== 32'h0)      begin failures++; $display("FAIL rst_waddr: got %0h want 0", bus.waddr); end
      if (bus.wdata !== 8'h0)       begin failures++; $display("FAIL rst_wdata: got %0h want 0", bus.wdata); end
      if (bus.busy !== 1'b0)        begin failures++; $display("FAIL rst_busy: got %0b want 0", bus.busy); end
      if (bus.cmd_ready !== 1'b1)   begin failures++; $display("FAIL rst_cmd_ready: got %0b want 1", bus.cmd_ready); end
      if (bus8.sel_rw !== 1'b0)     begin failures++; $display("FAIL rst_sel_rw8: got %0b want 0", bus8.sel_rw); end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_single();
      bit ok;
      int e0;
      bus.blank = 1'b1;
      clear_obs();
      send_cmd(32'h00EF_FF00, 8'd31, 8'd0, ok);
      e0 = cyc;
      repeat (3) step();
      checks += 6;
      if (!ok) begin failures++; $display("FAIL single_accept: accepted=0 required 1"); end
      if (obs_addr.size() != 1) begin
         failures++; $display("FAIL single_count: got %0d writes want 1", obs_addr.size());
      end else begin
         if (obs_cyc[0] != e0 + 2) begin failures++; $display("FAIL single_latency: got %0d want %0d", obs_cyc[0] - e0, 2); end
         if (obs_addr[0] !== 32'h00EF_FF00) begin failures++; $display("FAIL single_waddr: got %0h want 00efff00", obs_addr[0]); end
         if (obs_data[0] !== 8'd31) begin failures++; $display("FAIL single_wdata: got %0d want 31", obs_data[0]); end
      end
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL single_busy: got %0b want 0", bus.busy); end
   endtask

   task automatic test_wrap8();
      logic [7:0] a8 [$];
      logic [7:0] d8 [$];
      logic [7:0] base;
      base = 8'hFE;
      bus8.blank     = 1'b1;
      bus8.cmd_addr  = 8'hFE;
      bus8.cmd_data  = 8'h5A;
      bus8.cmd_len   = 8'd3;
      bus8.cmd_valid = 1'b1;
      @(posedge clk);
      #1 bus8.cmd_valid = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1;
         if (bus8.sel_rw === 1'b1) begin
            a8.push_back(bus8.waddr);
            d8.push_back(bus8.wdata);
         end
      end
      checks++;
      if (a8.size() != 4) begin
         failures++; $display("FAIL wrap_count: got %0d writes want 4", a8.size());
      end
      for (int i = 0; i < 4 && i < a8.size(); i++) begin
         logic [7:0] ea;
         ea = base + 8'(i);
         checks++;
         if (a8[i] !== ea || d8[i] !== 8'h5A) begin
            failures++;
            $display("FAIL wrap_write%0d: got addr=%0h data=%0h want addr=%0h data=5a", i, a8[i], d8[i], ea);
         end
      end
   endtask

   task automatic test_blank_pause();
      bit ok;
      int pause_left;
      logic [31:0] a;
      logic [7:0]  d;
      a = $urandom;
      d = 8'($urandom);
      pause_left = -1;
      bus.blank = 1'b1;
      clear_obs();
      model_cmd(a, d, 8'd9);
      send_cmd(a, d, 8'd9, ok);
      for (int k = 0; k < 40; k++) begin
         step();
         if (obs_addr.size() == 3 && pause_left < 0) begin
            bus.blank  = 1'b0;
            pause_left = 5;
         end else if (pause_left > 0) begin
            pause_left--;
            if (pause_left == 0) bus.blank = 1'b1;
         end
      end
      bus.blank = 1'b1;
      checks += 2;
      if (!ok) begin failures++; $display("FAIL pause_accept: accepted=0 required 1"); end
      if (obs_addr.size() != 10) begin
         failures++; $display("FAIL pause_count: got %0d writes want 10", obs_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
         checks++;
         if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
            failures++;
            $display("FAIL pause_write%0d: got %0h/%0h want %0h/%0h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
         end
      end
      if (obs_cyc.size() == 10) begin
         checks++;
         if (obs_cyc[9] - obs_cyc[0] != 9 + (BLANK_ONLY ? 5 : 0)) begin
            failures++;
            $display("FAIL pause_span: got %0d cycles want %0d", obs_cyc[9] - obs_cyc[0], 9 + (BLANK_ONLY ? 5 : 0));
         end
      end
   endtask

   task automatic test_full();
      bit ok;
      int nacc;
      logic [31:0] a;
      logic [7:0]  d;
      logic [7:0]  len;
      nacc = 0;
      bus.blank = 1'b0;
      clear_obs();
      for (int c = 0; c < 5; c++) begin
         a   = $urandom;
         d   = 8'($urandom);
         len = (c == 0) ? 8'd200 : 8'($urandom_range(0, 5));
         model_cmd(a, d, len);
         send_cmd(a, d, len, ok);
         if (ok) nacc++;
      end
      checks += 2;
      if (nacc != 5) begin failures++; $display("FAIL full_accepts: got %0d want 5", nacc); end
      if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL full_ready: got %0b want 0", bus.cmd_ready); end
      bus.cmd_addr  = 32'hDEAD_0000;
      bus.cmd_data  = 8'hEE;
      bus.cmd_len   = 8'd2;
      bus.cmd_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL full_hold%0d: ready=%0b want 0", k, bus.cmd_ready); end
         step();
      end
      bus.cmd_valid = 1'b0;
      bus.blank = 1'b1;
      drain(600);
      checks++;
      if (obs_addr.size() != exp_addr.size()) begin
         failures++; $display("FAIL full_count: got %0d writes want %0d", obs_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
         checks++;
         if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
            failures++;
            $display("FAIL full_write%0d: got %0h/%0h want %0h/%0h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
         end
      end
      if (obs_cyc.size() == exp_addr.size() && obs_cyc.size() > 0) begin
         checks++;
         if (obs_cyc[obs_cyc.size()-1] - obs_cyc[0] != exp_addr.size() - 1 + 4) begin
            failures++;
            $display("FAIL full_span: got %0d cycles want %0d", obs_cyc[obs_cyc.size()-1] - obs_cyc[0], exp_addr.size() + 3);
         end
      end
   endtask

   task automatic test_random();
      int idx;
      int k;
      bit v;
      bit r;
      logic [31:0] a;
      logic [7:0]  d;
      logic [7:0]  len;
      idx = 0;
      k   = 0;
      a   = '0;
      d   = '0;
      len = '0;
      clear_obs();
      while ((idx < 24 || bus.busy !== 1'b0) && k < 4000) begin
         if (idx < 24 && bus.cmd_valid !== 1'b1 && $urandom_range(0, 3) != 0) begin
            a   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 7))) : $urandom;
            d   = 8'($urandom);
            len = 8'($urandom_range(0, 6));
            bus.cmd_addr  = a;
            bus.cmd_data  = d;
            bus.cmd_len   = len;
            bus.cmd_valid = 1'b1;
         end
         bus.blank = ($urandom_range(0, 3) != 0);
         v = bus.cmd_valid;
         r = bus.cmd_ready;
         step();
         if (v && r) begin
            model_cmd(a, d, len);
            idx++;
            bus.cmd_valid = 1'b0;
         end
         k++;
      end
      bus.cmd_valid = 1'b0;
      bus.blank = 1'b1;
      checks += 2;
      if (k >= 4000) begin failures++; $display("FAIL rand_timeout: issued %0d of 24 busy=%0b", idx, bus.busy); end
      if (obs_addr.size() != exp_addr.size()) begin
         failures++; $display("FAIL rand_count: got %0d writes want %0d", obs_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
         checks++;
         if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
            failures++;
            $display("FAIL rand_write%0d: got %0h/%0h want %0h/%0h", i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit ok1, ok2, ok3;
      bus.blank = 1'b1;
      clear_obs();
      send_cmd(32'h0000_1000, 8'h11, 8'd7, ok1);
      send_cmd(32'h0000_2000, 8'h22, 8'd3, ok2);
      send_cmd(32'h0000_3000, 8'h33, 8'd3, ok3);
      for (int k = 0; k < 20 && obs_addr.size() < 2; k++) step();
      checks += 2;
      if (!(ok1 && ok2 && ok3)) begin failures++; $display("FAIL rmid_accept: got %0b%0b%0b want 111", ok1, ok2, ok3); end
      if (obs_addr.size() != 2) begin failures++; $display("FAIL rmid_prefill: got %0d writes want 2", obs_addr.size()); end
      rst = 1'b1;
      #1;
      checks += 3;
      if (bus.sel_rw !== 1'b0)    begin failures++; $display("FAIL rmid_sel_rw: got %0b want 0", bus.sel_rw); end
      if (bus.busy !== 1'b0)      begin failures++; $display("FAIL rmid_busy: got %0b want 0", bus.busy); end
      if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready: got %0b want 1", bus.cmd_ready); end
      @(posedge clk);
      #1 rst = 1'b0;
      clear_obs();
      repeat (20) step();
      checks += 2;
      if (obs_addr.size() != 0) begin failures++; $display("FAIL rmid_leftover: got %0d writes want 0", obs_addr.size()); end
      if (bus.busy !== 1'b0)    begin failures++; $display("FAIL rmid_busy_after: got %0b want 0", bus.busy); end
   endtask

   task automatic test_after_reset();
      bit ok;
      int e0;
      logic [31:0] a;
      logic [7:0]  d;
      a = $urandom;
      d = 8'($urandom);
      bus.blank = 1'b1;
      clear_obs();
      model_cmd(a, d, 8'd1);
      send_cmd(a, d, 8'd1, ok);
      e0 = cyc;
      repeat (6) step();
      checks += 2;
      if (!ok) begin failures++; $display("FAIL post_accept: accepted=0 required 1"); end
      if (obs_addr.size() != 2) begin
         failures++; $display("FAIL post_count: got %0d writes want 2", obs_addr.size());
      end else begin
         checks += 3;
         if (obs_cyc[0] != e0 + 2) begin failures++; $display("FAIL post_latency: got %0d want 2", obs_cyc[0] - e0); end
         if (obs_addr[0] !== exp_addr[0] || obs_data[0] !== exp_data[0]) begin
            failures++; $display("FAIL post_write0: got %0h/%0h want %0h/%0h", obs_addr[0], obs_data[0], exp_addr[0], exp_data[0]);
         end
         if (obs_addr[1] !== exp_addr[1] || obs_data[1] !== exp_data[1]) begin
            failures++; $display("FAIL post_write1: got %0h/%0h want %0h/%0h", obs_addr[1], obs_data[1], exp_addr[1], exp_data[1]);
         end
      end
   endtask

   initial begin
      rst            = 1'b0;
      bus.cmd_valid  = 1'b0;
      bus.cmd_addr   = '0;
      bus.cmd_data   = '0;
      bus.cmd_len    = '0;
      bus.blank      = 1'b0;
      bus8.cmd_valid = 1'b0;
      bus8.cmd_addr  = '0;
      bus8.cmd_data  = '0;
      bus8.cmd_len   = '0;
      bus8.blank     = 1'b0;

      test_reset();
      test_single();
      test_wrap8();
      test_blank_pause();
      test_full();
      test_random();
      test_reset_mid();
      test_after_reset();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
